// File: rtl/sharp_frame_ctrl_pkg.sv
// Shared definitions for the sharpening-filter frame controller: FSM encoding
// and default parameter values.
package sharp_frame_ctrl_pkg;

  localparam int unsigned COEF_WIDTH_DEF = 8;
  localparam int unsigned CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    DRAIN    = 2'd2
  } state_t;

endpackage

// File: rtl/sharp_frame_ctrl_if.sv
// Stream taps around the sharpening filter: upstream 3x3 handshake, gated
// filter-input handshake and the monitored filter-output stream.
interface sharp_frame_ctrl_if;

  logic up_val;
  logic up_rdy;
  logic up_sof;
  logic up_eof;
  logic up_sol;
  logic up_eol;
  logic flt_val;
  logic flt_rdy;
  logic flo_val;
  logic flo_rdy;
  logic flo_eof;

  // Environment side: drives the upstream stream and the filter taps.
  modport master (
    output up_val, up_sof, up_eof, up_sol, up_eol, flt_rdy, flo_val, flo_rdy, flo_eof,
    input  up_rdy, flt_val
  );

  // Controller side: observes everything, drives only the gated handshake.
  modport slave (
    input  up_val, up_sof, up_eof, up_sol, up_eol, flt_rdy, flo_val, flo_rdy, flo_eof,
    output up_rdy, flt_val
  );

endinterface

// File: rtl/sharp_frame_ctrl_frame_stat_cnt.sv
// Reusable frame/line statistics: running line counter, last-frame line latch
// and wrapping completed-frame counter.
module frame_stat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         line_clr,
  input  logic         line_inc,
  input  logic         line_latch,
  input  logic         frame_inc,
  output logic [W-1:0] sts_lines,
  output logic [W-1:0] sts_frames
);

  logic [W-1:0] line_cnt;
  logic [W-1:0] line_nxt;

  // A sof beat that also carries eol restarts the count and counts itself.
  assign line_nxt = (line_clr ? '0 : line_cnt) + {{(W-1){1'b0}}, line_inc};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt   <= '0;
      sts_lines  <= '0;
      sts_frames <= '0;
    end else begin
      if (line_clr || line_inc) line_cnt   <= line_nxt;
      if (line_latch)           sts_lines  <= line_nxt;
      if (frame_inc)            sts_frames <= sts_frames + 1'b1;
    end
  end

endmodule

// File: rtl/sharp_frame_ctrl.sv
// Frame-synchronous scheduler for the sharpening filter: commits shadowed
// coefficient writes only between drained frames and flags framing errors.
module sharp_frame_ctrl
  import sharp_frame_ctrl_pkg::*;
#(
  parameter int unsigned COEF_WIDTH = COEF_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr,
  input  logic [COEF_WIDTH-1:0] cfg_coef,
  input  logic                  cfg_en,
  input  logic                  cfg_clr_err,
  sharp_frame_ctrl_if.slave     bus,
  output logic [COEF_WIDTH-1:0] ctl_coef,
  output logic                  sts_busy,
  output logic                  sts_pend,
  output logic [CNT_WIDTH-1:0]  sts_frames,
  output logic [CNT_WIDTH-1:0]  sts_lines,
  output logic                  err_sof,
  output logic                  err_orph
);

  state_t                state, state_nxt;
  logic [COEF_WIDTH-1:0] shadow_coef;
  logic                  shadow_en;
  logic                  pend;
  logic                  in_x, out_x, out_eof;
  logic                  hold, commit;
  logic                  set_sof_err, set_orph_err;

  assign in_x    = bus.up_val & bus.up_rdy;
  assign out_x   = bus.flo_val & bus.flo_rdy;
  assign out_eof = out_x & bus.flo_eof;

  // Input is held off while a frame drains and for the one commit cycle.
  assign hold        = (state == DRAIN) | ((state == IDLE) & pend);
  assign bus.flt_val = bus.up_val & ~hold;
  assign bus.up_rdy  = bus.flt_rdy & ~hold;
  assign commit      = (state == IDLE) & pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    set_sof_err  = 1'b0;
    set_orph_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_x) begin
          if (bus.up_sof) state_nxt = bus.up_eof ? DRAIN : IN_FRAME;
          else            set_orph_err = 1'b1;
        end
      end
      IN_FRAME: begin
        if (in_x) begin
          set_sof_err = bus.up_sof;
          if (bus.up_eof) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_eof) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the shadow is reset like any other control register; a write that
  // is pending when reset hits is deliberately discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_coef <= '0;
      shadow_en   <= 1'b0;
      pend        <= 1'b0;
      ctl_coef    <= '0;
    end else begin
      // A write on the commit edge wins: pend stays set for a second commit.
      if (cfg_wr) begin
        shadow_coef <= cfg_coef;
        shadow_en   <= cfg_en;
        pend        <= 1'b1;
      end else if (commit) begin
        pend <= 1'b0;
      end
      if (commit) ctl_coef <= shadow_en ? shadow_coef : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sof  <= 1'b0;
      err_orph <= 1'b0;
    end else begin
      if (set_sof_err)      err_sof <= 1'b1;
      else if (cfg_clr_err) err_sof <= 1'b0;
      if (set_orph_err)     err_orph <= 1'b1;
      else if (cfg_clr_err) err_orph <= 1'b0;
    end
  end

  assign sts_busy = (state != IDLE);
  assign sts_pend = pend;

  frame_stat_cnt #(.W(CNT_WIDTH)) u_stat (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_clr   (in_x & bus.up_sof),
    .line_inc   (in_x & bus.up_eol & ((state != IDLE) | bus.up_sof)),
    .line_latch (in_x & bus.up_eof),
    .frame_inc  (out_eof),
    .sts_lines  (sts_lines),
    .sts_frames (sts_frames)
  );

endmodule

// File: tb/tb_sharp_frame_ctrl.sv
// Directed bench for sharp_frame_ctrl with a fixed-latency filter model and a
// per-frame scoreboard checked at each output eof.
module tb_sharp_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       cfg_wr, cfg_en, cfg_clr_err;
  logic [7:0] cfg_coef;

  logic [7:0]  ctl_coef, ctl_coef4;
  logic        sts_busy, sts_pend, err_sof, err_orph;
  logic        sts_busy4, sts_pend4, err_sof4, err_orph4;
  logic [15:0] sts_frames, sts_lines;
  logic [3:0]  sts_frames4, sts_lines4;

  sharp_frame_ctrl_if bus ();
  sharp_frame_ctrl_if bus4 ();

  // The narrow-counter instance sees exactly the same stream.
  assign bus4.up_val  = bus.up_val;
  assign bus4.up_sof  = bus.up_sof;
  assign bus4.up_eof  = bus.up_eof;
  assign bus4.up_sol  = bus.up_sol;
  assign bus4.up_eol  = bus.up_eol;
  assign bus4.flt_rdy = bus.flt_rdy;
  assign bus4.flo_val = bus.flo_val;
  assign bus4.flo_rdy = bus.flo_rdy;
  assign bus4.flo_eof = bus.flo_eof;

  sharp_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_coef(cfg_coef), .cfg_en(cfg_en),
    .cfg_clr_err(cfg_clr_err), .bus(bus), .ctl_coef(ctl_coef), .sts_busy(sts_busy),
    .sts_pend(sts_pend), .sts_frames(sts_frames), .sts_lines(sts_lines),
    .err_sof(err_sof), .err_orph(err_orph)
  );

  sharp_frame_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_coef(cfg_coef), .cfg_en(cfg_en),
    .cfg_clr_err(cfg_clr_err), .bus(bus4), .ctl_coef(ctl_coef4), .sts_busy(sts_busy4),
    .sts_pend(sts_pend4), .sts_frames(sts_frames4), .sts_lines(sts_lines4),
    .err_sof(err_sof4), .err_orph(err_orph4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Filter model: three-stage pipeline carrying eof and the coefficient in use.
  typedef struct packed {
    logic       v;
    logic       eof;
    logic [7:0] coef;
  } beat_t;

  beat_t pipe [0:2];
  wire   fire = bus.flt_val & bus.flt_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{v: fire, eof: fire & bus.up_eof, coef: ctl_coef};
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end

  assign bus.flo_val = pipe[2].v;
  assign bus.flo_eof = pipe[2].eof;

  typedef struct {
    int coef;
    int lines;
    int frames;
  } exp_t;

  exp_t sb [$];
  int   frames_exp = 0;
  beat_t mb;
  exp_t  me;

  task automatic push(input int coef, input int lines);
    frames_exp++;
    sb.push_back('{coef, lines, frames_exp});
  endtask

  always @(posedge clk) begin
    if (rst_n && bus.flo_val && bus.flo_rdy) begin
      mb = pipe[2];
      @(negedge clk);
      if (sb.size() == 0) begin
        if (mb.eof) chk("sb_underflow", sb.size(), 1);
      end else begin
        me = sb[0];
        chk("frame_coef", {24'b0, mb.coef}, me.coef);
        if (mb.eof) begin
          void'(sb.pop_front());
          chk("sts_lines",   {16'b0, sts_lines},   me.lines);
          chk("sts_frames",  {16'b0, sts_frames},  me.frames);
          chk("sts_frames4", {28'b0, sts_frames4}, me.frames & 15);
        end
      end
    end
  end

  task automatic beat(input logic sof, input logic eof, input logic eol);
    int i = 0;
    bus.up_val = 1'b1; bus.up_sof = sof; bus.up_eof = eof; bus.up_eol = eol;
    bus.up_sol = sof;
    @(negedge clk);
    while (!bus.up_rdy && i < 100) begin @(negedge clk); i++; end
    if (!bus.up_rdy) chk("beat_timeout", {31'b0, bus.up_rdy}, 1);
    @(posedge clk); #1;
    bus.up_val = 1'b0; bus.up_sof = 1'b0; bus.up_eof = 1'b0; bus.up_eol = 1'b0;
    bus.up_sol = 1'b0;
  endtask

  // wr_line >= 0 pulses cfg_wr with the first beat after that line;
  // sof_line > 0 injects an extra sof at the start of that line.
  task automatic send_frame(input int w, input int h, input int wr_line, input int sof_line);
    for (int l = 0; l < h; l++) begin
      for (int p = 0; p < w; p++) begin
        if (wr_line >= 0 && p == 0 && l == wr_line + 1) cfg_wr = 1'b1;
        beat(p == 0 && (l == 0 || l == sof_line), l == h - 1 && p == w - 1, p == w - 1);
        cfg_wr = 1'b0;
      end
    end
  endtask

  task automatic pulse_wr(input logic [7:0] coef, input logic en);
    cfg_coef = coef; cfg_en = en; cfg_wr = 1'b1;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (sts_busy && i < 300) begin @(negedge clk); i++; end
    chk(tag, {31'b0, sts_busy}, 0);
  endtask

  task automatic wait_done(input string tag);
    wait_idle(tag);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_wr = 1'b0; cfg_coef = '0; cfg_en = 1'b0; cfg_clr_err = 1'b0;
    bus.up_val = 1'b0; bus.up_sof = 1'b0; bus.up_eof = 1'b0; bus.up_sol = 1'b0;
    bus.up_eol = 1'b0; bus.flt_rdy = 1'b1; bus.flo_rdy = 1'b1;
    #23 rst_n = 1'b1;
    @(negedge clk);

    // Reset state and transparent gating.
    chk("rst_coef",   {24'b0, ctl_coef}, 0);
    chk("rst_busy",   {31'b0, sts_busy}, 0);
    chk("rst_pend",   {31'b0, sts_pend}, 0);
    chk("rst_frames", {16'b0, sts_frames}, 0);
    chk("rst_lines",  {16'b0, sts_lines}, 0);
    chk("rst_errs",   {30'b0, err_sof, err_orph}, 0);
    chk("rst_up_rdy", {31'b0, bus.up_rdy}, 1);
    bus.flt_rdy = 1'b0; bus.up_val = 1'b1;
    #1;
    chk("rdy_follow", {31'b0, bus.up_rdy}, 0);
    chk("val_follow", {31'b0, bus.flt_val}, 1);
    bus.flt_rdy = 1'b1; bus.up_val = 1'b0;

    // Idle write: commit one edge later, one cycle of backpressure.
    pulse_wr(8'h40, 1'b1);
    chk("iw_hold",     {31'b0, bus.up_rdy}, 0);
    chk("iw_pend",     {31'b0, sts_pend}, 1);
    chk("iw_pre_coef", {24'b0, ctl_coef}, 0);
    @(posedge clk); #1;
    chk("iw_coef",  {24'b0, ctl_coef}, 8'h40);
    chk("iw_rdy",   {31'b0, bus.up_rdy}, 1);
    chk("iw_unpend",{31'b0, sts_pend}, 0);

    push(8'h40, 3);
    send_frame(4, 3, -1, 0);
    chk("f1_drain_rdy", {31'b0, bus.up_rdy}, 0);
    chk("f1_busy",      {31'b0, sts_busy}, 1);
    chk("f1_lines",     {16'b0, sts_lines}, 3);
    wait_done("f1_idle");

    // Mid-frame write: held until the output eof, then committed.
    cfg_coef = 8'h80; cfg_en = 1'b1;
    push(8'h40, 3);
    send_frame(4, 3, 1, 0);
    chk("mf_drain_rdy", {31'b0, bus.up_rdy}, 0);
    chk("mf_pend",      {31'b0, sts_pend}, 1);
    chk("mf_old_coef",  {24'b0, ctl_coef}, 8'h40);
    wait_idle("mf_idle");
    chk("mf_commit_hold", {31'b0, bus.up_rdy}, 0);
    chk("mf_still_old",   {24'b0, ctl_coef}, 8'h40);
    @(posedge clk); #1;
    chk("mf_new_coef", {24'b0, ctl_coef}, 8'h80);
    chk("mf_unpend",   {31'b0, sts_pend}, 0);
    push(8'h80, 2);
    send_frame(2, 2, -1, 0);
    wait_done("f3_idle");

    // Write on the commit edge: first value commits, second follows.
    cfg_coef = 8'h11; cfg_en = 1'b1; cfg_wr = 1'b1;
    @(posedge clk); #1;
    cfg_coef = 8'h22;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    chk("cw_first", {24'b0, ctl_coef}, 8'h11);
    chk("cw_pend",  {31'b0, sts_pend}, 1);
    @(posedge clk); #1;
    chk("cw_second", {24'b0, ctl_coef}, 8'h22);

    // Disable forces a zero coefficient.
    pulse_wr(8'hFF, 1'b0);
    @(posedge clk); #1;
    chk("dis_coef", {24'b0, ctl_coef}, 0);

    // Sof mid-frame: error flag and line count restart.
    push(0, 2);
    send_frame(4, 3, -1, 1);
    chk("err_sof_set",  {31'b0, err_sof}, 1);
    chk("err_orph_clr", {31'b0, err_orph}, 0);
    wait_done("f4_idle");
    beat(1'b0, 1'b0, 1'b1);
    chk("orph_set",   {31'b0, err_orph}, 1);
    chk("orph_idle",  {31'b0, sts_busy}, 0);
    chk("orph_lines", {16'b0, sts_lines}, 2);
    cfg_clr_err = 1'b1;
    beat(1'b0, 1'b0, 1'b0);
    cfg_clr_err = 1'b0;
    chk("set_wins", {30'b0, err_sof, err_orph}, 2'b01);
    cfg_clr_err = 1'b1;
    @(posedge clk); #1;
    cfg_clr_err = 1'b0;
    chk("clr_both", {30'b0, err_sof, err_orph}, 0);
    repeat (4) @(posedge clk);
    #1;

    // Single-beat frame.
    push(0, 1);
    beat(1'b1, 1'b1, 1'b1);
    chk("sb_drain", {31'b0, sts_busy}, 1);
    chk("sb_lines", {16'b0, sts_lines}, 1);
    wait_done("sb_idle");

    // Reset during DRAIN with a pending write.
    push(0, 1);
    send_frame(3, 1, -1, 0);
    cfg_coef = 8'h33; cfg_en = 1'b1; cfg_wr = 1'b1;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    chk("rd_pend", {31'b0, sts_pend}, 1);
    chk("rd_busy", {31'b0, sts_busy}, 1);
    rst_n = 1'b0;
    sb.delete();
    frames_exp = 0;
    #1;
    chk("rd_outs", {sts_busy, sts_pend, err_sof, err_orph, ctl_coef}, 0);
    chk("rd_cnts", {sts_frames, sts_lines}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rd_after", {sts_busy, sts_pend, ctl_coef}, 0);

    // 17 one-line frames: the 4-bit frame counter wraps to 1.
    for (int f = 0; f < 17; f++) begin
      push(0, 1);
      send_frame(2, 1, -1, 0);
      wait_done("wrap_idle");
    end
    chk("wrap_frames4", {28'b0, sts_frames4}, 1);
    chk("wrap_lines4",  {28'b0, sts_lines4}, 1);
    chk("wrap_frames",  {16'b0, sts_frames}, 17);
    chk("sb_drained",   sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
